// File: rtl/rock_drive.sv
// rock_drive: rocking-mode drive controller with a PSfreq square wave and a PSamp PWM.
// Latency: targets register on the accept edge; levels follow by one step per tick wrap, or in one RAMP cycle.
// Backpressure: req_ready is low in STOP/FAULT and in any cycle with error=1. Macro ROCK_SOFTRAMP_EN enables stepped ramps.
module rock_drive #(
    parameter int AW        = 3,
    parameter int FW        = 3,
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 1024,
    parameter int HALF_BASE = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] amp_req,
    input  logic [FW-1:0] freq_req,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          error,
    input  logic          fault_clr,
    output logic          PSfreq,
    output logic          PSamp,
    output logic [AW-1:0] amp_cur,
    output logic [FW-1:0] freq_cur,
    output logic          busy,
    output logic          fault
);

    // Parameter sanity checks at elaboration time
    if (PWM_W < AW) begin : g_bad_pwm_w
        $error("rock_drive: PWM_W must be >= AW");
    end
    if (RAMP_DIV < 1) begin : g_bad_ramp_div
        $error("rock_drive: RAMP_DIV must be >= 1");
    end
    if (HALF_BASE < 1) begin : g_bad_half_base
        $error("rock_drive: HALF_BASE must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, RAMP, HOLD, STOP, FAULT} state_t;

    state_t        state;
    logic [AW-1:0] amp_tgt;
    logic [FW-1:0] freq_tgt;
    logic          rdy_en;     // stays low until the first edge after reset
    logic          open_st;
    logic          accept;
    logic [AW-1:0] amp_nxt;
    logic [FW-1:0] freq_nxt;
    logic          settle;

    assign open_st   = (state == IDLE) || (state == RAMP) || (state == HOLD);
    assign req_ready = rdy_en && open_st && !error;
    assign accept    = req_valid && req_ready;

`ifdef ROCK_SOFTRAMP_EN
    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;

    assign tick_wrap = (tick_cnt == TW'(RAMP_DIV - 1));

    // Free-running ramp tick; never restarted by a new request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         tick_cnt <= '0;
        else if (tick_wrap) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + 1'b1;
    end

    // Candidate levels: one step toward target per tick wrap, each level independently
    always_comb begin
        amp_nxt  = amp_cur;
        freq_nxt = freq_cur;
        if (tick_wrap) begin
            if (amp_cur < amp_tgt)       amp_nxt = amp_cur + 1'b1;
            else if (amp_cur > amp_tgt)  amp_nxt = amp_cur - 1'b1;
            if (freq_cur < freq_tgt)     freq_nxt = freq_cur + 1'b1;
            else if (freq_cur > freq_tgt) freq_nxt = freq_cur - 1'b1;
        end
    end
`else
    // Without soft ramping the levels jump straight to the targets
    assign amp_nxt  = amp_tgt;
    assign freq_nxt = freq_tgt;
`endif

    assign settle = (amp_nxt == amp_tgt) && (freq_nxt == freq_tgt);

    // Control FSM with registered busy/fault; an accept or error edge holds the levels for that edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            amp_tgt  <= '0;
            freq_tgt <= '0;
            amp_cur  <= '0;
            freq_cur <= '0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE, RAMP, HOLD: begin
                    if (error) begin
                        amp_tgt  <= '0;
                        freq_tgt <= '0;
                        state    <= STOP;
                        busy     <= 1'b1;
                    end else if (accept) begin
                        amp_tgt  <= amp_req;
                        freq_tgt <= freq_req;
                        if ((amp_req == amp_cur) && (freq_req == freq_cur)) begin
                            state <= ((amp_req == '0) && (freq_req == '0)) ? IDLE : HOLD;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end else if (state == RAMP) begin
                        amp_cur  <= amp_nxt;
                        freq_cur <= freq_nxt;
                        if (settle) begin
                            state <= ((amp_tgt == '0) && (freq_tgt == '0)) ? IDLE : HOLD;
                            busy  <= 1'b0;
                        end
                    end
                end
                STOP: begin
                    amp_cur  <= amp_nxt;
                    freq_cur <= freq_nxt;
                    if (settle) begin
                        state <= FAULT;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    amp_cur  <= '0;
                    freq_cur <= '0;
                    if (fault_clr && !error) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

    // Amplitude PWM: duty is amp_cur scaled to the top bits of the counter
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] amp_thr;

    assign amp_thr = PWM_W'(amp_cur) << (PWM_W - AW);
    assign PSamp   = (pwm_cnt < amp_thr);

    // Free-running PWM counter, wraps naturally at 2^PWM_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Half-period length is sampled at the first cycle of each half so a change never cuts one short
    localparam int HW = $clog2((2 ** FW) * HALF_BASE + 1);
    localparam logic [HW-1:0] FSPAN = HW'(2 ** FW);
    localparam logic [HW-1:0] HBASE = HW'(HALF_BASE);

    logic [HW-1:0] half_cnt;
    logic [HW-1:0] half_len;
    logic [HW-1:0] half_new;
    logic [HW-1:0] half_now;

    assign half_new = (FSPAN - HW'(freq_cur)) * HBASE;
    assign half_now = (half_cnt == '0) ? half_new : half_len;

    // PSfreq generator; freq_cur=0 parks the output low with the counter cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PSfreq   <= 1'b0;
            half_cnt <= '0;
            half_len <= '0;
        end else if (freq_cur == '0) begin
            PSfreq   <= 1'b0;
            half_cnt <= '0;
        end else begin
            if (half_cnt == '0) half_len <= half_new;
            if (half_cnt == half_now - 1'b1) begin
                PSfreq   <= ~PSfreq;
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/rock_drive.md
ROCK_DRIVE -- requirements
Module: rock_drive

Interface
REQ-001 SHALL have parameter AW, default 3: amplitude level width.
REQ-002 SHALL have parameter FW, default 3: frequency level width.
REQ-003 SHALL have parameter PWM_W, default 8: PSamp PWM counter width; PWM_W >= AW.
REQ-004 SHALL have parameter RAMP_DIV, default 1024: clk ticks per ramp step.
REQ-005 SHALL have parameter HALF_BASE, default 256: clk ticks per PSfreq half-period unit.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port amp_req, input, AW: target amplitude level.
REQ-009 SHALL have port freq_req, input, FW: target frequency level.
REQ-010 SHALL have port req_valid, input, 1: target offered.
REQ-011 SHALL have port req_ready, output, 1: target accepted when req_valid && req_ready.
REQ-012 SHALL have port error, input, 1: controller error, level-sensitive.
REQ-013 SHALL have port fault_clr, input, 1: leave FAULT.
REQ-014 SHALL have port PSfreq, output, 1: rocking frequency square wave.
REQ-015 SHALL have port PSamp, output, 1: amplitude PWM.
REQ-016 SHALL have ports amp_cur (AW) and freq_cur (FW), outputs: current applied levels.
REQ-017 SHALL have ports busy and fault, outputs, 1 each: ramp in progress; in FAULT.

Function
REQ-018 SHALL implement states IDLE, RAMP, HOLD, STOP, FAULT.
REQ-019 req_ready SHALL be 1 in IDLE, RAMP, HOLD and 0 in STOP, FAULT, and 0 in any cycle where error=1.
REQ-020 On accept, targets SHALL register next edge; state -> RAMP unless targets equal current levels (-> HOLD, or IDLE if both 0).
REQ-021 A free-running tick counter SHALL wrap every RAMP_DIV cycles; on wrap in RAMP/STOP, amp_cur and freq_cur SHALL each move one step toward target independently.
REQ-022 RAMP SHALL go to HOLD when both levels equal targets, or IDLE if both targets are 0.
REQ-023 A new accept during RAMP/HOLD SHALL replace targets without resetting the tick counter.
REQ-024 error=1 in IDLE/RAMP/HOLD SHALL set targets to 0 and enter STOP next edge; error beats simultaneous req_valid (request dropped).
REQ-025 STOP SHALL ramp down per REQ-021 and enter FAULT when both levels reach 0.
REQ-026 FAULT SHALL hold levels 0; fault_clr=1 with error=0 SHALL return to IDLE next edge; fault_clr ignored while error=1.
REQ-027 busy SHALL be 1 in RAMP and STOP; fault SHALL be 1 only in FAULT.
REQ-028 PSamp SHALL be 1 when pwm_cnt < {amp_cur, (PWM_W-AW) zeros}; amp_cur=0 gives constant 0; pwm_cnt wraps at 2^PWM_W.
REQ-029 PSfreq SHALL toggle every (2^FW - freq_cur)*HALF_BASE cycles; freq_cur=0 holds PSfreq at 0 and clears its counter.
REQ-030 A change of freq_cur SHALL take effect at the next PSfreq toggle, never truncating a running half-period.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, all counters 0, targets 0, amp_cur=0, freq_cur=0, PSfreq=0, PSamp=0, busy=0, fault=0, req_ready=0.
REQ-032 req_ready SHALL rise the first clk edge after reset deasserts; reset mid-ramp abandons the ramp.

Configuration
REQ-033 Macro ROCK_SOFTRAMP_EN defined SHALL enable REQ-021 stepping; undefined, levels SHALL jump to targets on the edge after accept (RAMP and STOP last one cycle), tick counter removed.

Verification
REQ-034 Reset, accept amp=5 freq=3 with RAMP_DIV=4 -> amp_cur 1..5 one step per 4 cycles, freq_cur stops at 3, then HOLD, busy=0.
REQ-035 In HOLD amp_cur=4, AW=3, PWM_W=8 -> PSamp high 128 of 256 cycles; freq_cur=7, HALF_BASE=2 -> PSfreq toggles every 2 cycles.
REQ-036 error=1 concurrent with req_valid in HOLD amp=3 -> request dropped, STOP, 3 ramp-downs, FAULT, fault=1; fault_clr with error=1 ignored, with error=0 -> IDLE.
REQ-037 Mid-ramp (amp_cur=2, target 6) new target 1 -> ramps down to 1 then HOLD.
REQ-038 reset pulsed low mid-ramp -> all outputs 0 asynchronously; ROCK_SOFTRAMP_EN undefined: accept amp=6 -> amp_cur=6 next edge.
